alu_seq: RTL and testbench

//  Multi-cycle BCD arithmetic sequencer behind the calculator control FSM.
//  - Takes the FSM's one-cycle ALU-enable pulse plus the latched operands and operator.
//  - Runs add, sub or mul digit-serially on one shared BCD digit adder.
//  - Returns result, sign and error with a one-cycle done pulse.
//  - The display mux reads result/neg/err. The FSM waits for done before showing the result.

---
 rtl/calc_pkg.sv | 24 ++
 rtl/bcd_digit_add.sv | 19 +
 rtl/alu_seq.sv | 223 ++++++++++++++++++++++
 tb/tb_alu_seq.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator BCD arithmetic sequencer:
// operator codes, sequencer state encoding, default digit count and
// a BCD digit-validity helper.
package calc_pkg;

    localparam int NDIG_DEF = 4;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CHECK   = 3'd1;
    localparam logic [2:0] S_CMP     = 3'd2;
    localparam logic [2:0] S_ADDLOOP = 3'd3;
    localparam logic [2:0] S_SHIFT   = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    function automatic logic bcd_digit_valid(input logic [3:0] d);
        return (d <= 4'd9);
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD adder with decimal (+6) correction.
// Inputs are assumed to be valid BCD digits.
module bcd_digit_add (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] raw;
    logic [4:0] adj;

    assign raw  = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    assign cout = (raw > 5'd9);
    assign adj  = raw + 5'd6;
    assign sum  = cout ? adj[3:0] : raw[3:0];

endmodule

// File: rtl/alu_seq.sv
// Digit-serial BCD add/sub/mul sequencer. One shared digit adder is stepped
// LSD-first across the operand; multiply is shift-and-repeated-add over the
// multiplier digits MSD-first. Results are published on entry to DONE.
module alu_seq
    import calc_pkg::*;
#(
    parameter int NDIG = NDIG_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [4*NDIG-1:0] a_bcd,
    input  logic [4*NDIG-1:0] b_bcd,
    output logic              busy,
    output logic              done,
    output logic [4*NDIG-1:0] result,
    output logic              neg,
    output logic              err
);

    localparam int W  = 4 * NDIG;
    localparam int DW = (NDIG > 1) ? $clog2(NDIG) : 1;

    logic [2:0]    state_q, state_d;
    logic [1:0]    op_q, op_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d, acc_q, acc_d;
    logic [DW-1:0] dig_q, dig_d, mdig_q, mdig_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          carry_q, carry_d;
    logic          negw_q, negw_d;
    logic [W-1:0]  result_q, result_d;
    logic          neg_q, neg_d, err_q, err_d;

    logic [3:0]    a_dig [NDIG];
    logic [3:0]    b_dig [NDIG];
    logic [3:0]    acc_dig [NDIG];
    logic [NDIG-1:0] a_bad, b_bad;
    logic [W-1:0]  acc_upd;
    logic [W-1:0]  acc_shl;
    logic [3:0]    add_x, add_y, add_sum;
    logic          add_cin, add_cout;
    logic          last_dig;

    // Per-digit views of the working registers, validity flags, and the
    // accumulator with the current digit replaced by the adder output.
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_dig
        assign a_dig[gi]   = a_q[4*gi +: 4];
        assign b_dig[gi]   = b_q[4*gi +: 4];
        assign acc_dig[gi] = acc_q[4*gi +: 4];
        assign a_bad[gi]   = !bcd_digit_valid(a_dig[gi]);
        assign b_bad[gi]   = !bcd_digit_valid(b_dig[gi]);
        assign acc_upd[4*gi +: 4] = (dig_q == DW'(gi)) ? add_sum : acc_dig[gi];
    end

    assign acc_shl  = {acc_q[W-5:0], 4'h0};
    assign last_dig = (dig_q == DW'(NDIG - 1));

    // Operand steering for the shared digit adder (sub uses 9's complement).
    always_comb begin
        add_x   = a_dig[dig_q];
        add_y   = b_dig[dig_q];
        add_cin = carry_q;
        if (op_q == OP_SUB) begin
            add_y = 4'd9 - b_dig[dig_q];
        end else if (op_q == OP_MUL) begin
            add_x = acc_dig[dig_q];
            add_y = a_dig[dig_q];
        end
    end

    bcd_digit_add u_add (
        .a    (add_x),
        .b    (add_y),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Sequencer next-state and datapath updates; outputs change only on DONE entry.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        dig_d    = dig_q;
        mdig_d   = mdig_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        negw_d   = negw_q;
        result_d = result_q;
        neg_d    = neg_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a_bcd;
                    b_d     = b_bcd;
                    op_d    = op;
                    negw_d  = 1'b0;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                dig_d   = '0;
                carry_d = 1'b0;
                acc_d   = '0;
                if ((|a_bad) || (|b_bad) || (op_q == OP_RSV)) begin
                    result_d = '0; neg_d = 1'b0; err_d = 1'b1;
                    state_d  = S_DONE;
                end else if (op_q == OP_ADD) begin
                    state_d = S_ADDLOOP;
                end else if (op_q == OP_SUB) begin
                    state_d = S_CMP;
                end else begin
                    mdig_d  = DW'(NDIG - 1);
                    state_d = S_SHIFT;
                end
            end
            S_CMP: begin
                if (a_q < b_q) begin
                    a_d    = b_q;
                    b_d    = a_q;
                    negw_d = 1'b1;
                end
                dig_d   = '0;
                carry_d = 1'b1;
                state_d = S_ADDLOOP;
            end
            S_ADDLOOP: begin
                acc_d   = acc_upd;
                carry_d = add_cout;
                dig_d   = dig_q + DW'(1);
                if (last_dig) begin
                    if (op_q == OP_SUB) begin
                        result_d = acc_upd; neg_d = negw_q; err_d = 1'b0;
                        state_d  = S_DONE;
                    end else if (add_cout) begin
                        result_d = '0; neg_d = 1'b0; err_d = 1'b1;
                        state_d  = S_DONE;
                    end else if (op_q == OP_ADD) begin
                        result_d = acc_upd; neg_d = 1'b0; err_d = 1'b0;
                        state_d  = S_DONE;
                    end else if (cnt_q > 4'd1) begin
                        cnt_d   = cnt_q - 4'd1;
                        dig_d   = '0;
                        carry_d = 1'b0;
                    end else if (mdig_q == '0) begin
                        result_d = acc_upd; neg_d = 1'b0; err_d = 1'b0;
                        state_d  = S_DONE;
                    end else begin
                        mdig_d  = mdig_q - DW'(1);
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                if (acc_q[W-1 -: 4] != 4'h0) begin
                    result_d = '0; neg_d = 1'b0; err_d = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    acc_d = acc_shl;
                    if (b_dig[mdig_q] == 4'h0) begin
                        if (mdig_q == '0) begin
                            result_d = acc_shl; neg_d = 1'b0; err_d = 1'b0;
                            state_d  = S_DONE;
                        end else begin
                            mdig_d = mdig_q - DW'(1);
                        end
                    end else begin
                        cnt_d   = b_dig[mdig_q];
                        dig_d   = '0;
                        carry_d = 1'b0;
                        state_d = S_ADDLOOP;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            op_q     <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            dig_q    <= '0;
            mdig_q   <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            negw_q   <= 1'b0;
            result_q <= '0;
            neg_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            dig_q    <= dig_d;
            mdig_q   <= mdig_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            negw_q   <= negw_d;
            result_q <= result_d;
            neg_q    <= neg_d;
            err_q    <= err_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
    assign neg    = neg_q;
    assign err    = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed cases followed by randomized
// operations, all compared against an integer-arithmetic reference model.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [1:0]  op;
    logic [15:0] a_bcd, b_bcd;
    logic        busy, done, neg, err;
    logic [15:0] result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_seq #(.NDIG(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .op     (op),
        .a_bcd  (a_bcd),
        .b_bcd  (b_bcd),
        .busy   (busy),
        .done   (done),
        .result (result),
        .neg    (neg),
        .err    (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int bcd2int(input logic [15:0] v);
        return int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [15:0] int2bcd(input int n);
        logic [15:0] r;
        r[15:12] = 4'((n / 1000) % 10);
        r[11:8]  = 4'((n / 100) % 10);
        r[7:4]   = 4'((n / 10) % 10);
        r[3:0]   = 4'(n % 10);
        return r;
    endfunction

    function automatic bit all_valid(input logic [15:0] v);
        return (v[15:12] <= 9) && (v[11:8] <= 9) && (v[7:4] <= 9) && (v[3:0] <= 9);
    endfunction

    // Reference: decimal arithmetic plus the latency rules in cycles.
    task automatic model(input logic [15:0] a, input logic [15:0] b, input logic [1:0] o,
                         output logic [15:0] r, output logic n, output logic e, output int lat);
        int ai, bi, acc, d;
        int pw[4];
        bit stop;
        pw[0] = 1000; pw[1] = 100; pw[2] = 10; pw[3] = 1;
        r = '0; n = 1'b0; e = 1'b0; lat = 1;
        if (!all_valid(a) || !all_valid(b) || o == 2'b11) begin
            e = 1'b1;
        end else begin
            ai = bcd2int(a);
            bi = bcd2int(b);
            if (o == 2'b00) begin
                lat = 5;
                if (ai + bi > 9999) e = 1'b1;
                else r = int2bcd(ai + bi);
            end else if (o == 2'b01) begin
                lat = 6;
                if (ai < bi) begin r = int2bcd(bi - ai); n = 1'b1; end
                else r = int2bcd(ai - bi);
            end else begin
                acc = 0; stop = 0;
                for (int i = 0; i < 4 && !stop; i++) begin
                    d = (bi / pw[i]) % 10;
                    lat += 1;
                    if (acc >= 1000) begin e = 1'b1; stop = 1; end
                    else begin
                        acc *= 10;
                        for (int p = 0; p < d && !stop; p++) begin
                            lat += 4;
                            acc += ai;
                            if (acc > 9999) begin e = 1'b1; stop = 1; end
                        end
                    end
                end
                if (!stop) r = int2bcd(acc);
            end
        end
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [1:0] o,
                          input bit inject, input string name);
        logic [15:0] er, held_r;
        logic        en, ee, held_n, held_e;
        int          el, lat;
        bit          hold_ok, busy_ok;
        model(a, b, o, er, en, ee, el);
        @(negedge clk);
        a_bcd = a; b_bcd = b; op = o; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a_bcd = 16'($urandom); b_bcd = 16'($urandom); op = 2'($urandom);
        held_r = result; held_n = neg; held_e = err;
        lat = 0; hold_ok = 1; busy_ok = 1;
        while (done !== 1'b1 && lat < 400) begin
            if (busy !== 1'b1) busy_ok = 0;
            if (result !== held_r || neg !== held_n || err !== held_e) hold_ok = 0;
            start = (inject && lat == 1) ? 1'b1 : 1'b0;
            if (inject && lat == 1) begin a_bcd = 16'h0001; b_bcd = 16'h0001; op = 2'b00; end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        check({name, ".latency"}, lat, el);
        check({name, ".result"}, result, er);
        check({name, ".neg"}, neg, en);
        check({name, ".err"}, err, ee);
        check({name, ".busy_at_done"}, busy, 1'b1);
        check({name, ".busy_while_running"}, busy_ok, 1'b1);
        check({name, ".outputs_held"}, hold_ok, 1'b1);
        @(posedge clk); #1;
        check({name, ".done_pulse_end"}, done, 1'b0);
        check({name, ".idle_after"}, busy, 1'b0);
        check({name, ".result_kept"}, result, er);
        $display("%s: op=%0d a=%h b=%h -> result=%h neg=%0d err=%0d lat=%0d (exp %h/%0d/%0d/%0d)",
                 name, o, a, b, result, neg, err, lat, er, en, ee, el);
    endtask

    initial begin
        logic [15:0] ra, rb;
        logic [1:0]  ro;
        int          nib;

        resetn = 1'b0; start = 1'b0; op = 2'b00; a_bcd = '0; b_bcd = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.busy", busy, 1'b0);
        check("reset.done", done, 1'b0);
        check("reset.result", result, 16'h0000);
        check("reset.neg", neg, 1'b0);
        check("reset.err", err, 1'b0);
        @(negedge clk);
        resetn = 1'b1;

        run_op(16'h0123, 16'h0456, 2'b00, 0, "add_basic");
        run_op(16'h0100, 16'h0250, 2'b01, 0, "sub_negative");
        run_op(16'h0250, 16'h0250, 2'b01, 0, "sub_zero");
        run_op(16'h0012, 16'h0012, 2'b10, 0, "mul_basic");
        run_op(16'h0012, 16'h0000, 2'b10, 0, "mul_by_zero");
        run_op(16'h9999, 16'h0001, 2'b00, 0, "add_overflow");
        run_op(16'h0100, 16'h0100, 2'b10, 0, "mul_shift_ovf");
        run_op(16'h00A1, 16'h0001, 2'b00, 0, "invalid_digit");
        run_op(16'h0001, 16'h0002, 2'b11, 0, "reserved_op");
        run_op(16'h0321, 16'h0045, 2'b01, 1, "start_ignored");
        run_op(16'h0123, 16'h0456, 2'b00, 0, "add_again");

        // Asynchronous reset in the middle of a multiply.
        @(negedge clk);
        a_bcd = 16'h0012; b_bcd = 16'h0012; op = 2'b10; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("midreset.busy_before", busy, 1'b1);
        resetn = 1'b0;
        #1;
        check("midreset.busy", busy, 1'b0);
        check("midreset.done", done, 1'b0);
        check("midreset.result", result, 16'h0000);
        check("midreset.neg", neg, 1'b0);
        check("midreset.err", err, 1'b0);
        $display("midreset: busy=%0d done=%0d result=%h neg=%0d err=%0d", busy, done, result, neg, err);
        @(negedge clk);
        resetn = 1'b1;
        run_op(16'h0001, 16'h0001, 2'b00, 0, "add_after_reset");

        for (int t = 0; t < 40; t++) begin
            ro = 2'($urandom_range(0, 3));
            if (ro == 2'b10 && $urandom_range(0, 1) == 1) begin
                ra = int2bcd($urandom_range(0, 999));
                rb = int2bcd($urandom_range(0, 99));
            end else begin
                ra = int2bcd($urandom_range(0, 9999));
                rb = int2bcd($urandom_range(0, 9999));
            end
            if ($urandom_range(0, 7) == 0) begin
                nib = $urandom_range(0, 3);
                if ($urandom_range(0, 1) == 1) ra[nib*4 +: 4] = 4'($urandom_range(10, 15));
                else rb[nib*4 +: 4] = 4'($urandom_range(10, 15));
            end
            run_op(ra, rb, ro, ($urandom_range(0, 3) == 0), "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
